// File: rtl/multicycle_cu.sv
// ---------------------------------------------------------------------------
// multicycle_cu : control unit for a multicycle RV32I(+M) datapath.
//
// The FSM walks every instruction through FETCH -> DECODE -> EXEC and then,
// depending on the instruction class, MUL_WAIT, MEM and/or WB. Any illegal
// encoding or an expired handshake wait ends in a sticky TRAP state.
//
// Parameters
//   ENABLE_M   : 1 decodes RV32M (funct7=0000001 on 0110011), 0 traps it
//   WAIT_LIMIT : max cycles spent waiting on mem_ready / mul_done, 0 = off
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   opCode/funct3/funct7     fields of the latched instruction
//   mem_ready, mul_done      handshake completions
//   mem_req, mem_we, DMCtrl  memory request, write enable, size/sign
//   IRWr, PCWr               instruction register load, PC update
//   ALUAsrc/ALUBsrc/ALUOp    ALU operand selects and operation
//   ImmSrc, BrOp             immediate format, branch/jump control
//   RUWr, RUDataWrSrc        register write enable and data source
//   mul_start                one-cycle start pulse to the M unit
//   trap, trap_cause, state  status (cause 01 illegal, 10 timeout)
// ---------------------------------------------------------------------------
module multicycle_cu #(
   parameter int ENABLE_M   = 1,
   parameter int WAIT_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opCode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   input  logic       mul_done,
   output logic       mem_req,
   output logic       mem_we,
   output logic [2:0] DMCtrl,
   output logic       IRWr,
   output logic       PCWr,
   output logic       ALUAsrc,
   output logic       ALUBsrc,
   output logic [4:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic [4:0] BrOp,
   output logic       RUWr,
   output logic [1:0] RUDataWrSrc,
   output logic       mul_start,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_DECODE   = 3'd1,
      S_EXEC     = 3'd2,
      S_MUL_WAIT = 3'd3,
      S_MEM      = 3'd4,
      S_WB       = 3'd5,
      S_TRAP     = 3'd6
   } state_t;

   // The counter only ever holds 0..WAIT_LIMIT-1 because the FSM leaves the
   // wait state on the cycle it would reach WAIT_LIMIT.
   localparam int            CW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
   localparam logic          EN_M   = (ENABLE_M != 0);
   localparam logic          EN_LIM = (WAIT_LIMIT != 0);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    cause_reg, cause_next;

   // instruction class decode
   logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
   logic m_enc, is_m, legal, limit_hit, waiting;

   assign is_r     = (opCode == 7'b0110011);
   assign is_i     = (opCode == 7'b0010011);
   assign is_ld    = (opCode == 7'b0000011);
   assign is_st    = (opCode == 7'b0100011);
   assign is_br    = (opCode == 7'b1100011);
   assign is_lui   = (opCode == 7'b0110111);
   assign is_auipc = (opCode == 7'b0010111);
   assign is_jal   = (opCode == 7'b1101111);
   assign is_jalr  = (opCode == 7'b1100111);
   assign m_enc    = is_r && (funct7 == 7'b0000001);
   assign is_m     = m_enc && EN_M;
   assign legal    = (is_r && !(m_enc && !EN_M)) || is_i || is_ld || is_st ||
                     is_br || is_lui || is_auipc || is_jal || is_jalr;

   // last permitted waiting cycle: completion now still wins, else timeout
   assign limit_hit = EN_LIM && (cnt_reg == LIM_M1);
   assign waiting   = (state_reg == S_FETCH) || (state_reg == S_MEM) ||
                      (state_reg == S_MUL_WAIT);

   // datapath control decode, independent of FSM state
   logic [4:0] dec_alu_op;
   logic [2:0] dec_imm_src;
   logic       dec_a_src, dec_b_src;
   logic [4:0] dec_br_op;
   logic [1:0] dec_wr_src;

   always_comb begin
      dec_alu_op  = 5'b00000;
      dec_imm_src = 3'b000;
      dec_a_src   = 1'b0;
      dec_b_src   = 1'b1;
      dec_br_op   = 5'b00000;
      dec_wr_src  = 2'b00;
      if (is_r) begin
         dec_b_src  = 1'b0;
         dec_alu_op = is_m ? {2'b10, funct3} : {1'b0, funct7[5], funct3};
      end
      if (is_i) begin
         // only SRAI uses funct7[5] to pick the arithmetic variant
         dec_alu_op = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
      end
      if (is_st) dec_imm_src = 3'b001;
      if (is_lui || is_auipc) dec_imm_src = 3'b010;
      if (is_auipc) dec_a_src = 1'b1;
      if (is_br) begin
         dec_imm_src = 3'b101;
         dec_a_src   = 1'b1;
         dec_br_op   = {1'b1, funct3, 1'b0};
      end
      if (is_jal) begin
         dec_imm_src = 3'b110;
         dec_a_src   = 1'b1;
         dec_br_op   = 5'b00001;
         dec_wr_src  = 2'b10;
      end
      if (is_jalr) begin
         dec_br_op  = 5'b00010;
         dec_wr_src = 2'b10;
      end
      if (is_ld) dec_wr_src = 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
         cnt_reg   <= '0;
         cause_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cause_reg <= cause_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cause_next  = cause_reg;
      cnt_next    = cnt_reg;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      DMCtrl      = 3'b000;
      IRWr        = 1'b0;
      PCWr        = 1'b0;
      ALUAsrc     = 1'b0;
      ALUBsrc     = 1'b0;
      ALUOp       = 5'b00000;
      ImmSrc      = 3'b000;
      BrOp        = 5'b00000;
      RUWr        = 1'b0;
      RUDataWrSrc = 2'b00;
      mul_start   = 1'b0;

      case (state_reg)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               IRWr       = 1'b1;
               state_next = S_DECODE;
            end else if (limit_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_next = S_EXEC;
            end else begin
               state_next = S_TRAP;
               cause_next = 2'b01;
            end
         end
         S_EXEC: begin
            if (is_m) begin
               mul_start  = 1'b1;
               state_next = S_MUL_WAIT;
            end else if (is_ld || is_st) begin
               state_next = S_MEM;
            end else if (is_br) begin
               PCWr       = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_WB;
            end
         end
         S_MUL_WAIT: begin
            if (mul_done) begin
               state_next = S_WB;
            end else if (limit_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_st;
            DMCtrl  = funct3;
            if (mem_ready) begin
               if (is_ld) begin
                  state_next = S_WB;
               end else begin
                  PCWr       = 1'b1;
                  state_next = S_FETCH;
               end
            end else if (limit_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_WB: begin
            RUWr       = 1'b1;
            PCWr       = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP: begin
            state_next = S_TRAP;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      // datapath controls are meaningful only once the instruction is latched
      if ((state_reg != S_FETCH) && (state_reg != S_TRAP)) begin
         ALUAsrc     = dec_a_src;
         ALUBsrc     = dec_b_src;
         ALUOp       = dec_alu_op;
         ImmSrc      = dec_imm_src;
         BrOp        = dec_br_op;
         RUDataWrSrc = dec_wr_src;
      end

      // the counter restarts on every state change, so entering any wait
      // state begins at zero
      if (state_next != state_reg) begin
         cnt_next = '0;
      end else if (waiting && EN_LIM) begin
         cnt_next = cnt_reg + 1'b1;
      end

      // reset silences every output combinationally, so a request in flight
      // drops the moment rst_n falls rather than at the next edge
      if (!rst_n) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         DMCtrl      = 3'b000;
         IRWr        = 1'b0;
         PCWr        = 1'b0;
         ALUAsrc     = 1'b0;
         ALUBsrc     = 1'b0;
         ALUOp       = 5'b00000;
         ImmSrc      = 3'b000;
         BrOp        = 5'b00000;
         RUWr        = 1'b0;
         RUDataWrSrc = 2'b00;
         mul_start   = 1'b0;
      end
   end

   assign state      = state_reg;
   assign trap       = (state_reg == S_TRAP);
   assign trap_cause = cause_reg;

endmodule

// File: tb/tb_multicycle_cu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_cu : randomized self-checking bench for multicycle_cu.
// Main DUT: ENABLE_M=1, WAIT_LIMIT=4. Second DUT: ENABLE_M=0, WAIT_LIMIT=0,
// driven with the same inputs, used for the M-disabled and no-limit cases.
// Expected per-cycle behaviour is derived from the instruction class.
// ---------------------------------------------------------------------------
module tb_multicycle_cu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [6:0] opCode, funct7;
   logic [2:0] funct3;
   logic       mem_ready, mul_done;

   logic       mem_req, mem_we, IRWr, PCWr, ALUAsrc, ALUBsrc, RUWr, mul_start, trap;
   logic [2:0] DMCtrl, ImmSrc, state;
   logic [4:0] ALUOp, BrOp;
   logic [1:0] RUDataWrSrc, trap_cause;

   logic       b_mem_req, b_mem_we, b_IRWr, b_PCWr, b_ALUAsrc, b_ALUBsrc, b_RUWr;
   logic       b_mul_start, b_trap;
   logic [2:0] b_DMCtrl, b_ImmSrc, b_state;
   logic [4:0] b_ALUOp, b_BrOp;
   logic [1:0] b_RUDataWrSrc, b_trap_cause;

   multicycle_cu #(.ENABLE_M(1), .WAIT_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .mul_done(mul_done), .mem_req(mem_req), .mem_we(mem_we),
      .DMCtrl(DMCtrl), .IRWr(IRWr), .PCWr(PCWr), .ALUAsrc(ALUAsrc), .ALUBsrc(ALUBsrc),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc), .BrOp(BrOp), .RUWr(RUWr),
      .RUDataWrSrc(RUDataWrSrc), .mul_start(mul_start), .trap(trap),
      .trap_cause(trap_cause), .state(state)
   );

   multicycle_cu #(.ENABLE_M(0), .WAIT_LIMIT(0)) dut_nom (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .mul_done(mul_done), .mem_req(b_mem_req), .mem_we(b_mem_we),
      .DMCtrl(b_DMCtrl), .IRWr(b_IRWr), .PCWr(b_PCWr), .ALUAsrc(b_ALUAsrc),
      .ALUBsrc(b_ALUBsrc), .ALUOp(b_ALUOp), .ImmSrc(b_ImmSrc), .BrOp(b_BrOp),
      .RUWr(b_RUWr), .RUDataWrSrc(b_RUDataWrSrc), .mul_start(b_mul_start),
      .trap(b_trap), .trap_cause(b_trap_cause), .state(b_state)
   );

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

   // enable vector bits: {mem_req, mem_we, IRWr, PCWr, RUWr, mul_start, trap}
   localparam logic [6:0] MREQ = 7'b1000000, MWE = 7'b0100000, IRW = 7'b0010000;
   localparam logic [6:0] PCW = 7'b0001000, RUW = 7'b0000100, MST = 7'b0000010;
   localparam logic [6:0] TRP = 7'b0000001, NONE = 7'b0000000;

   localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MULW = 3'd3;
   localparam logic [2:0] MEM = 3'd4, WB = 3'd5, TRAPS = 3'd6;

   int n_pass = 0;
   int n_checks = 0;

   logic [6:0] cur_op = OP_R;
   logic [2:0] cur_f3 = 3'b000;
   logic [6:0] cur_f7 = 7'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // expected {ALUOp, ImmSrc, ALUAsrc, ALUBsrc, BrOp} for an instruction
   function automatic logic [14:0] exp_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
      logic [4:0] alu, br;
      logic [2:0] imm;
      logic       asrc, bsrc;
      alu = 5'd0; br = 5'd0; imm = 3'd0; asrc = 1'b0; bsrc = 1'b1;
      case (op)
         OP_R: begin
            bsrc = 1'b0;
            alu  = (f7 == 7'h01) ? {2'b10, f3} : {1'b0, f7[5], f3};
         end
         OP_I:     alu = {1'b0, (f3 == 3'b101) && f7[5], f3};
         OP_ST:    imm = 3'b001;
         OP_LUI:   imm = 3'b010;
         OP_AUIPC: begin imm = 3'b010; asrc = 1'b1; end
         OP_BR:    begin imm = 3'b101; asrc = 1'b1; br = {1'b1, f3, 1'b0}; end
         OP_JAL:   begin imm = 3'b110; asrc = 1'b1; br = 5'b00001; end
         OP_JALR:  br = 5'b00010;
         default:  ;
      endcase
      return {alu, imm, asrc, bsrc, br};
   endfunction

   // one clock cycle: drive at negedge, check state and enables just after
   task automatic step(input logic [2:0] es, input logic [6:0] een, input logic mr,
                       input logic md, input string tag);
      @(negedge clk);
      opCode = cur_op; funct3 = cur_f3; funct7 = cur_f7;
      mem_ready = mr; mul_done = md;
      #1;
      chk({tag, " state"}, 32'(state), 32'(es));
      chk({tag, " en"}, 32'({mem_req, mem_we, IRWr, PCWr, RUWr, mul_start, trap}), 32'(een));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
      opCode = OP_ST; funct3 = 3'b111; funct7 = 7'h20;
      #1;
      chk("rst state", 32'(state), 32'(FETCH));
      chk("rst en", 32'({mem_req, mem_we, IRWr, PCWr, RUWr, mul_start, trap, trap_cause}), 0);
      chk("rst ctrl", 32'({ALUOp, ImmSrc, BrOp, RUDataWrSrc, DMCtrl, ALUAsrc, ALUBsrc}), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post rst", 32'({state, trap, trap_cause}), 0);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int lf, input int lw);
      logic m, ld, st, br, ok;
      cur_op = op; cur_f3 = f3; cur_f7 = f7;
      m  = (op == OP_R) && (f7 == 7'h01);
      ld = (op == OP_LD);
      st = (op == OP_ST);
      br = (op == OP_BR);
      ok = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
      $display("instr op=%b f3=%b f7=%b fetch_lat=%0d wait_lat=%0d", op, f3, f7, lf, lw);
      for (int c = 1; c <= lf; c++)
         step(FETCH, MREQ | ((c == lf) ? IRW : NONE), c == lf, rb(), "fetch");
      step(DECODE, NONE, rb(), rb(), "decode");
      if (!ok) begin
         for (int c = 0; c < 3; c++) begin
            step(TRAPS, TRP, rb(), rb(), "illegal");
            chk("illegal cause", 32'(trap_cause), 32'd1);
         end
         do_reset();
         return;
      end
      step(EXEC, (m ? MST : NONE) | (br ? PCW : NONE), rb(), rb(), "exec");
      chk("exec ctrl", 32'({ALUOp, ImmSrc, ALUAsrc, ALUBsrc, BrOp}), 32'(exp_ctrl(op, f3, f7)));
      if (m) begin
         chk("nom trap", 32'({b_state, b_trap, b_trap_cause}), 32'({TRAPS, 1'b1, 2'b01}));
         for (int c = 1; c <= lw; c++) step(MULW, NONE, rb(), c == lw, "mulwait");
      end
      if (ld || st) begin
         for (int c = 1; c <= lw; c++) begin
            step(MEM, MREQ | (st ? MWE : NONE) | ((st && c == lw) ? PCW : NONE),
                 c == lw, rb(), "mem");
            chk("mem dmctrl", 32'(DMCtrl), 32'(f3));
         end
      end
      if (!br && !st) begin
         step(WB, RUW | PCW, rb(), rb(), "wb");
         chk("wb src", 32'(RUDataWrSrc), ld ? 32'd1 : ((op == OP_JAL || op == OP_JALR) ? 32'd2 : 32'd0));
      end
   endtask

   logic [6:0] op_tab [10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC,
                               OP_JAL, OP_JALR, 7'b0000000};

   initial begin
      rst_n = 1'b1; mem_ready = 1'b0; mul_done = 1'b0;
      opCode = OP_R; funct3 = 3'b000; funct7 = 7'b0;
      do_reset();

      run_instr(OP_R, 3'b000, 7'h00, 1, 1);        // ADD
      run_instr(OP_LD, 3'b010, 7'h00, 1, 3);       // LW, memory after 3 cycles
      run_instr(OP_R, 3'b000, 7'h01, 2, 4);        // MUL, done on the last allowed cycle
      run_instr(OP_ST, 3'b001, 7'h00, 4, 2);       // fetch completes on 4th cycle
      run_instr(OP_BR, 3'b101, 7'h00, 1, 1);
      run_instr(OP_I, 3'b101, 7'h20, 3, 1);        // SRAI

      // fetch timeout: never ready within 4 cycles
      do_reset();
      cur_op = OP_R; cur_f3 = 3'b000; cur_f7 = 7'h00;
      for (int c = 1; c <= 4; c++) step(FETCH, MREQ, 1'b0, rb(), "tmo fetch");
      step(TRAPS, TRP, rb(), rb(), "tmo trap");
      chk("tmo cause", 32'(trap_cause), 32'd2);
      chk("nolimit fetch", 32'({b_state, b_mem_req}), 32'({FETCH, 1'b1}));
      step(TRAPS, TRP, 1'b1, 1'b1, "tmo sticky");

      // illegal opcode, sticky, cleared by reset
      do_reset();
      run_instr(7'b1111111, 3'b000, 7'h00, 1, 1);

      // reset while a load sits in MEM
      cur_op = OP_LD; cur_f3 = 3'b000; cur_f7 = 7'h00;
      step(FETCH, MREQ | IRW, 1'b1, 1'b0, "rm fetch");
      step(DECODE, NONE, 1'b0, 1'b0, "rm decode");
      step(EXEC, NONE, 1'b0, 1'b0, "rm exec");
      step(MEM, MREQ, 1'b0, 1'b0, "rm mem");
      rst_n = 1'b0;
      #1;
      chk("rm drop", 32'({state, mem_req, mem_we}), 32'({FETCH, 2'b00}));
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(FETCH, MREQ, 1'b0, 1'b0, "rm refetch");
      do_reset();

      for (int i = 0; i < 40; i++) begin
         logic [6:0] f7;
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom_range(0, 127));
         endcase
         run_instr(op_tab[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), f7,
                   $urandom_range(1, 4), $urandom_range(1, 4));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
